fir_wb_master: RTL

FIR_WB_MASTER -- requirements
Module: fir_wb_master

---
 rtl/fir_wb_master_pkg.sv | 35 +++
 rtl/fir_wbm_access.sv | 33 +++
 rtl/fir_wb_master.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/fir_wb_master_pkg.sv
// FIR Wishbone master: shared FSM state type and core register offsets.
// Offsets are word indices into the FIR core register window.
package fir_wb_master_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_W_ADDR,
        S_W_DATA,
        S_W_STB1,
        S_W_STB0,
        S_NXT1,
        S_NXT0,
        S_POLL,
        S_SETTLE,
        S_R_ADDR,
        S_R_DATA,
        S_OUT,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [2:0] OFS_NEXT   = 3'd0;
    localparam logic [2:0] OFS_WSTB   = 3'd1;
    localparam logic [2:0] OFS_WADDR  = 3'd2;
    localparam logic [2:0] OFS_WDATA  = 3'd3;
    localparam logic [2:0] OFS_RADDR  = 3'd4;
    localparam logic [2:0] OFS_STATUS = 3'd4;
    localparam logic [2:0] OFS_RDATA  = 3'd7;

    function automatic logic [31:0] ofs_addr(input logic [31:0] base,
                                             input logic [2:0]  ofs);
        return base + {27'd0, ofs, 2'b00};
    endfunction

endpackage

// File: rtl/fir_wbm_access.sv
// Single Wishbone access sequencer: holds cyc/stb while a request is
// posted and reports completion (ack) or failure (err) for that cycle.
module fir_wbm_access (
    input  logic        req,
    input  logic        we,
    input  logic [31:0] adr,
    input  logic [31:0] wdat,
    output logic        cyc,
    output logic        stb,
    output logic        bus_we,
    output logic [31:0] bus_adr,
    output logic [31:0] bus_wdat,
    input  logic        ack,
    input  logic        err,
    input  logic [31:0] bus_rdat,
    output logic [31:0] rdata,
    output logic        done,
    output logic        fail
);

    // Request stays on the bus until the slave answers; data only on writes.
    always_comb begin
        cyc      = req;
        stb      = req;
        bus_we   = req & we;
        bus_adr  = req ? adr : 32'd0;
        bus_wdat = (req & we) ? wdat : 32'd0;
        rdata    = bus_rdat;
        done     = req & ack & ~err;
        fail     = req & err;
    end

endmodule

// File: rtl/fir_wb_master.sv
// FIR Wishbone master: streams a block of samples into the FIR core,
// triggers it, polls for completion and streams the results back out.
module fir_wb_master
    import fir_wb_master_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          NSAMP     = 32,
    parameter int          POLL_MAX  = 1024,
    parameter int          SETTLE    = 40
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_we_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        err,
    input  logic [31:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [31:0] m_data,
    output logic        m_valid,
    input  logic        m_ready
);

    localparam int PW = $clog2(POLL_MAX + 1);
    localparam int SW = $clog2(SETTLE + 2);

    state_t        state;
    state_t        nstate;
    logic [5:0]    idx;
    logic [PW-1:0] poll_cnt;
    logic [SW-1:0] wait_cnt;
    logic [31:0]   sample;
    logic          have;
    logic [31:0]   m_data_q;
    logic          err_q;

    logic          req;
    logic          we;
    logic [2:0]    ofs;
    logic [31:0]   wdat;
    logic          acc_done;
    logic          acc_fail;
    logic [31:0]   acc_rdata;

    logic          last_idx;
    logic          last_poll;
    logic          settled;

    assign last_idx  = (int'(idx) + 1 >= NSAMP);
    assign last_poll = (int'(poll_cnt) + 1 >= POLL_MAX);
    assign settled   = (int'(wait_cnt) + 1 >= SETTLE);

    assign wbm_sel_o = 4'hF;
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE) || (state == S_ERR);
    assign err       = err_q;
    assign s_ready   = (state == S_W_DATA) && !have;
    assign m_valid   = (state == S_OUT);
    assign m_data    = m_data_q;

    fir_wbm_access u_acc (
        .req      (req),
        .we       (we),
        .adr      (ofs_addr(BASE_ADDR, ofs)),
        .wdat     (wdat),
        .cyc      (wbm_cyc_o),
        .stb      (wbm_stb_o),
        .bus_we   (wbm_we_o),
        .bus_adr  (wbm_adr_o),
        .bus_wdat (wbm_dat_o),
        .ack      (wbm_ack_i),
        .err      (wbm_err_i),
        .bus_rdat (wbm_dat_i),
        .rdata    (acc_rdata),
        .done     (acc_done),
        .fail     (acc_fail)
    );

    // Bus request posted by each state; W_DATA waits for a captured sample.
    always_comb begin
        req  = 1'b0;
        we   = 1'b0;
        ofs  = OFS_NEXT;
        wdat = 32'd0;
        unique case (state)
            S_W_ADDR: begin
                req  = 1'b1;
                we   = 1'b1;
                ofs  = OFS_WADDR;
                wdat = {26'd0, idx};
            end
            S_W_DATA: begin
                req  = have;
                we   = 1'b1;
                ofs  = OFS_WDATA;
                wdat = sample;
            end
            S_W_STB1: begin
                req  = 1'b1;
                we   = 1'b1;
                ofs  = OFS_WSTB;
                wdat = 32'd1;
            end
            S_W_STB0: begin
                req = 1'b1;
                we  = 1'b1;
                ofs = OFS_WSTB;
            end
            S_NXT1: begin
                req  = 1'b1;
                we   = 1'b1;
                ofs  = OFS_NEXT;
                wdat = 32'd1;
            end
            S_NXT0: begin
                req = 1'b1;
                we  = 1'b1;
                ofs = OFS_NEXT;
            end
            S_POLL: begin
                req = 1'b1;
                ofs = OFS_STATUS;
            end
            S_R_ADDR: begin
                req  = 1'b1;
                we   = 1'b1;
                ofs  = OFS_RADDR;
                wdat = {26'd0, idx};
            end
            S_R_DATA: begin
                req = 1'b1;
                ofs = OFS_RDATA;
            end
            default: ;
        endcase
    end

    // Next state; any bus error overrides and aborts the block.
    always_comb begin
        nstate = state;
        unique case (state)
            S_IDLE:   if (start) nstate = S_W_ADDR;
            S_W_ADDR: if (acc_done) nstate = S_W_DATA;
            S_W_DATA: if (acc_done) nstate = S_W_STB1;
            S_W_STB1: if (acc_done) nstate = S_W_STB0;
            S_W_STB0: if (acc_done) nstate = last_idx ? S_NXT1 : S_W_ADDR;
            S_NXT1:   if (acc_done) nstate = S_NXT0;
            S_NXT0:   if (acc_done) nstate = S_POLL;
            S_POLL: begin
                if (acc_done) begin
                    if (acc_rdata[0]) nstate = S_SETTLE;
                    else if (last_poll) nstate = S_ERR;
                end
            end
            S_SETTLE: if (settled) nstate = S_R_ADDR;
            S_R_ADDR: if (acc_done) nstate = S_R_DATA;
            S_R_DATA: if (acc_done) nstate = S_OUT;
            S_OUT:    if (m_ready) nstate = last_idx ? S_DONE : S_R_ADDR;
            S_DONE:   nstate = S_IDLE;
            S_ERR:    nstate = S_IDLE;
            default:  nstate = S_IDLE;
        endcase
        if (acc_fail) nstate = S_ERR;
    end

    // State, index, poll/settle counters, sample and result registers.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state    <= S_IDLE;
            idx      <= '0;
            poll_cnt <= '0;
            wait_cnt <= '0;
            sample   <= '0;
            have     <= 1'b0;
            m_data_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state <= nstate;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        idx      <= '0;
                        poll_cnt <= '0;
                        wait_cnt <= '0;
                        have     <= 1'b0;
                        err_q    <= 1'b0;
                    end
                end
                S_W_DATA: begin
                    if (!have && s_valid) begin
                        sample <= s_data;
                        have   <= 1'b1;
                    end else if (acc_done) begin
                        have <= 1'b0;
                    end
                end
                S_W_STB0: begin
                    if (acc_done) idx <= last_idx ? 6'd0 : idx + 6'd1;
                end
                S_NXT0: begin
                    if (acc_done) poll_cnt <= '0;
                end
                S_POLL: begin
                    if (acc_done) begin
                        wait_cnt <= '0;
                        if (!acc_rdata[0] && poll_cnt != PW'(POLL_MAX))
                            poll_cnt <= poll_cnt + PW'(1);
                    end
                end
                S_SETTLE: wait_cnt <= wait_cnt + SW'(1);
                S_R_DATA: begin
                    if (acc_done) m_data_q <= acc_rdata;
                end
                S_OUT: begin
                    if (m_ready && !last_idx) idx <= idx + 6'd1;
                end
                default: ;
            endcase
            if (nstate == S_ERR) err_q <= 1'b1;
        end
    end

endmodule
